mshr_miss_queue: RTL and testbench
==================================

# mshr_miss_queue

Miss-status holding queue on the response side of the global-memory cache path. It accepts coalesced misses from memory stage 2 and holds each one for its emulated miss latency. When the latency expires it returns the line-fill notification to the cache latency emulator (`fill_valid_o` and `fill_addr_o` drive `mshr_neg_feedback_valid` and `mshr_neg_feedback_addr`). It then replays the request, with its warp, scoreboard and thread context, back into the memory pipeline.

## Interface
- `ENTRIES`, default 4: number of MSHR entries, legal range 2..8.
- `clk`  in  1  clock, rising edge.
- `resetb`  in  1  reset, asynchronous, active-low.
- `miss_valid_i`  in  1  miss present this cycle (from stage 2: `addr_valid_o` and not `hit_missbar_o`).
- `miss_addr_i`  in  27  line address, i.e. `addr[31:5]`.
- `miss_latency_i`  in  5  emulated latency, in cycles.
- `miss_warp_ID_i`  in  3  warp ID of the miss.
- `miss_scb_ID_i`  in  2  scoreboard ID of the miss.
- `miss_reg_addr_i`  in  5  destination register.
- `miss_thread_mask_i`  in  8  thread mask of the miss.
- `miss_is_write_i`  in  1  1 = store, 0 = load.
- `full_o`  out  1  all entries occupied.
- `count_o`  out  4  number of occupied entries.
- `overflow_o`  out  1  sticky: a miss was presented while `full_o`=1.
- `fill_valid_o`  out  1  one-cycle line-fill notification.
- `fill_addr_o`  out  27  address of the filled line.
- `replay_valid_o`  out  1  replay request.
- `replay_ready_i`  in  1  pipeline accepts the replay.
- `replay_addr_o`  out  27  replay line address.
- `replay_warp_ID_o`  out  3  replay warp ID.
- `replay_scb_ID_o`  out  2  replay scoreboard ID.
- `replay_reg_addr_o`  out  5  replay destination register.
- `replay_thread_mask_o`  out  8  replay thread mask.
- `replay_is_write_o`  out  1  replay store/load flag.

## Operation
- Each entry holds: state, 5-bit countdown `cnt`, and the captured miss fields.
- Entry states:
  - FREE → WAIT on allocation.
  - WAIT → FILL when `cnt`=0; otherwise `cnt` decrements by 1 each cycle.
  - FILL → READY when the entry wins the fill port.
  - READY → FREE on the replay handshake (`replay_valid_o` & `replay_ready_i`).
- Allocation:
  - An edge with `miss_valid_i`=1 and `full_o`=0 writes the lowest-index FREE entry, with `cnt`=`miss_latency_i` and state WAIT.
  - The FREE set is the pre-edge FREE set; an entry freed on the same edge is not reused on that edge.
- Overflow: `miss_valid_i`=1 while `full_o`=1 drops the miss and sets `overflow_o`. Only reset clears `overflow_o`.
- Fill port:
  - `fill_valid_o` = any entry in FILL; `fill_addr_o` = address of the lowest-index FILL entry; one grant per cycle.
  - The granted entry moves to READY on that edge. Other FILL entries remain in FILL, so no fill is ever lost.
- Replay port:
  - `replay_valid_o` = any entry in READY; the `replay_*` fields come from the lowest-index READY entry (fixed priority).
  - The selected entry is held stable until the handshake. A newly READY lower-index entry never pre-empts a presented replay; a 1-bit hold register locks the index while valid=1 and ready=0.
- No address merging: two misses to the same line yield two fills and two replays.
- When the corresponding valid is 0, `fill_addr_o` and all `replay_*` data fields are 0.
- `count_o` = number of non-FREE entries; `full_o` = (`count_o` == `ENTRIES`). Both derive from registered state only.
- All outputs are functions of registered state only; there is no combinational input-to-output path.

## Timing
- Reset (asynchronous): all entries FREE, hold register clear, `overflow_o`=0. All outputs 0: `full_o`, `count_o`, `fill_valid_o`, `fill_addr_o`, `replay_*`.
- Reset asserted mid-operation discards all entries immediately; there is no drain.
- Miss captured at edge t with latency L:
  - Entry enters FILL at edge t+L+1.
  - `fill_valid_o`=1 during cycle t+L+1..t+L+2 if uncontended.
  - `replay_valid_o`=1 from edge t+L+2.
- L=0 gives the minimum latency: fill one cycle after capture, replay two cycles after capture.
- `count_o` on the edge after a simultaneous allocate and replay-free is unchanged.
- `full_o` rises on the edge that fills the last free entry.

## Test plan
- Single miss, addr 0x0000123, L=3, `replay_ready_i`=1 → `fill_valid_o` pulse with `fill_addr_o`=0x0000123 exactly 4 cycles after capture. Replay with identical warp/scb/reg/mask the next cycle. `count_o` then returns to 0.
- Two misses captured on the same latency expiry (entries 0 and 1 both enter FILL together) → two consecutive single-cycle fills, entry 0 first. No fill dropped.
- `replay_ready_i`=0 for 5 cycles with entries 0 and 2 READY, and entry 1 becomes READY mid-stall → fields stay on entry 0 throughout. After ready, entry 1 then entry 2 replay.
- `ENTRIES`=4: five back-to-back misses, L=10 → `full_o`=1 after the 4th. 5th dropped, `overflow_o`=1 sticky. `count_o`=4.
- Full queue; replay handshake and a new miss on the same edge → new miss dropped (`full_o` was 1). On the next attempt the new miss is accepted into the freed index.
- `resetb` pulsed low while 3 entries are in WAIT/FILL/READY → all outputs 0 immediately. No fill or replay is issued after release.

Source files
------------

// File: rtl/mshr_miss_queue_if.sv
// Bundles the miss-capture bus, the status flags, the line-fill
// notification and the replay handshake of the MSHR miss queue.
// The producer/consumer side (memory stage 2 plus pipeline) uses the
// master modport; the queue itself uses the slave modport.
interface mshr_miss_queue_if;
    // Miss capture from memory stage 2
    logic        miss_valid_i;
    logic [26:0] miss_addr_i;
    logic [4:0]  miss_latency_i;
    logic [2:0]  miss_warp_ID_i;
    logic [1:0]  miss_scb_ID_i;
    logic [4:0]  miss_reg_addr_i;
    logic [7:0]  miss_thread_mask_i;
    logic        miss_is_write_i;

    // Occupancy status
    logic        full_o;
    logic [3:0]  count_o;
    logic        overflow_o;

    // Line-fill notification to the cache latency emulator
    logic        fill_valid_o;
    logic [26:0] fill_addr_o;

    // Replay back into the memory pipeline
    logic        replay_valid_o;
    logic        replay_ready_i;
    logic [26:0] replay_addr_o;
    logic [2:0]  replay_warp_ID_o;
    logic [1:0]  replay_scb_ID_o;
    logic [4:0]  replay_reg_addr_o;
    logic [7:0]  replay_thread_mask_o;
    logic        replay_is_write_o;

    modport master (
        output miss_valid_i, miss_addr_i, miss_latency_i, miss_warp_ID_i,
               miss_scb_ID_i, miss_reg_addr_i, miss_thread_mask_i, miss_is_write_i,
               replay_ready_i,
        input  full_o, count_o, overflow_o, fill_valid_o, fill_addr_o,
               replay_valid_o, replay_addr_o, replay_warp_ID_o, replay_scb_ID_o,
               replay_reg_addr_o, replay_thread_mask_o, replay_is_write_o
    );

    modport slave (
        input  miss_valid_i, miss_addr_i, miss_latency_i, miss_warp_ID_i,
               miss_scb_ID_i, miss_reg_addr_i, miss_thread_mask_i, miss_is_write_i,
               replay_ready_i,
        output full_o, count_o, overflow_o, fill_valid_o, fill_addr_o,
               replay_valid_o, replay_addr_o, replay_warp_ID_o, replay_scb_ID_o,
               replay_reg_addr_o, replay_thread_mask_o, replay_is_write_o
    );
endinterface

// File: rtl/mshr_miss_queue.sv
// Miss-status holding queue. Each entry captures one coalesced miss,
// counts down its emulated latency, issues a one-cycle line-fill
// notification through a shared fill port, then replays the request
// (warp, scoreboard, register, thread mask) back into the pipeline.
// Both shared ports use fixed lowest-index priority; the replay port
// locks its selection while a presented request is stalled.
module mshr_miss_queue #(
    parameter int ENTRIES = 4
) (
    input  logic             clk,
    input  logic             resetb,
    mshr_miss_queue_if.slave bus
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FILL  = 2'd2,
        ST_READY = 2'd3
    } entry_state_e;

    // Per-entry views exported from the generate blocks
    entry_state_e st_arr   [ENTRIES];
    logic [26:0]  addr_arr [ENTRIES];
    logic [2:0]   warp_arr [ENTRIES];
    logic [1:0]   scb_arr  [ENTRIES];
    logic [4:0]   rga_arr  [ENTRIES];
    logic [7:0]   mask_arr [ENTRIES];
    logic         wr_arr   [ENTRIES];

    // Shared arbitration / status
    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] ready_idx;
    logic [IW-1:0] replay_idx;
    logic          any_fill;
    logic          any_ready;
    logic [3:0]    count;
    logic          full;
    logic          alloc_en;
    logic          replay_fire;

    // Replay selection lock and sticky overflow
    logic          hold_reg;
    logic          hold_next;
    logic [IW-1:0] hold_idx_reg;
    logic [IW-1:0] hold_idx_next;
    logic          overflow_reg;
    logic          overflow_next;

    // Scan entries: lowest-index FREE / FILL / READY entry and occupancy.
    // Iterating from the top down lets the lowest index win.
    always_comb begin
        alloc_idx = '0;
        fill_idx  = '0;
        ready_idx = '0;
        any_fill  = 1'b0;
        any_ready = 1'b0;
        count     = 4'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st_arr[i] == ST_FREE) begin
                alloc_idx = IW'(i);
            end
            if (st_arr[i] == ST_FILL) begin
                any_fill = 1'b1;
                fill_idx = IW'(i);
            end
            if (st_arr[i] == ST_READY) begin
                any_ready = 1'b1;
                ready_idx = IW'(i);
            end
            if (st_arr[i] != ST_FREE) begin
                count = count + 4'd1;
            end
        end
    end

    // Allocation uses the pre-edge FREE set only, so an entry freed by a
    // replay on this edge is not reused until the following edge.
    always_comb begin
        full        = (count == 4'(ENTRIES));
        alloc_en    = bus.miss_valid_i && !full;
        replay_idx  = hold_reg ? hold_idx_reg : ready_idx;
        replay_fire = any_ready && bus.replay_ready_i;
    end

    // Lock the presented replay while it is stalled; track overflow
    always_comb begin
        hold_next     = any_ready && !bus.replay_ready_i;
        hold_idx_next = hold_next ? replay_idx : '0;
        overflow_next = overflow_reg || (bus.miss_valid_i && full);
    end

    // Replay lock and sticky overflow registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hold_reg     <= 1'b0;
            hold_idx_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            hold_reg     <= hold_next;
            hold_idx_reg <= hold_idx_next;
            overflow_reg <= overflow_next;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        entry_state_e state_reg;
        entry_state_e state_next;
        logic [4:0]   cnt_reg;
        logic [4:0]   cnt_next;
        logic [26:0]  addr_reg;
        logic [2:0]   warp_reg;
        logic [1:0]   scb_reg;
        logic [4:0]   rga_reg;
        logic [7:0]   mask_reg;
        logic         wr_reg;
        logic         alloc_hit;
        logic         fill_grant;
        logic         replay_done;

        assign alloc_hit   = alloc_en    && (alloc_idx  == IW'(gi));
        assign fill_grant  = any_fill    && (fill_idx   == IW'(gi));
        assign replay_done = replay_fire && (replay_idx == IW'(gi));

        // Entry lifecycle: FREE -> WAIT (count down) -> FILL -> READY -> FREE
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
                ST_FREE: begin
                    if (alloc_hit) begin
                        state_next = ST_WAIT;
                        cnt_next   = bus.miss_latency_i;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 5'd0) begin
                        state_next = ST_FILL;
                    end else begin
                        cnt_next = cnt_reg - 5'd1;
                    end
                end
                ST_FILL: begin
                    if (fill_grant) begin
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (replay_done) begin
                        state_next = ST_FREE;
                    end
                end
                default: begin
                    state_next = ST_FREE;
                end
            endcase
        end

        // Entry state and countdown registers; reset discards the entry
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                state_reg <= ST_FREE;
                cnt_reg   <= 5'd0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        // Captured miss context; only meaningful while the entry is busy
        always_ff @(posedge clk) begin
            if (alloc_hit) begin
                addr_reg <= bus.miss_addr_i;
                warp_reg <= bus.miss_warp_ID_i;
                scb_reg  <= bus.miss_scb_ID_i;
                rga_reg  <= bus.miss_reg_addr_i;
                mask_reg <= bus.miss_thread_mask_i;
                wr_reg   <= bus.miss_is_write_i;
            end
        end

        assign st_arr[gi]   = state_reg;
        assign addr_arr[gi] = addr_reg;
        assign warp_arr[gi] = warp_reg;
        assign scb_arr[gi]  = scb_reg;
        assign rga_arr[gi]  = rga_reg;
        assign mask_arr[gi] = mask_reg;
        assign wr_arr[gi]   = wr_reg;
    end

    // Output ports: registered state only; data fields forced to 0 when idle
    always_comb begin
        bus.full_o               = full;
        bus.count_o              = count;
        bus.overflow_o           = overflow_reg;
        bus.fill_valid_o         = any_fill;
        bus.fill_addr_o          = any_fill ? addr_arr[fill_idx] : 27'd0;
        bus.replay_valid_o       = any_ready;
        bus.replay_addr_o        = 27'd0;
        bus.replay_warp_ID_o     = 3'd0;
        bus.replay_scb_ID_o      = 2'd0;
        bus.replay_reg_addr_o    = 5'd0;
        bus.replay_thread_mask_o = 8'd0;
        bus.replay_is_write_o    = 1'b0;
        if (any_ready) begin
            bus.replay_addr_o        = addr_arr[replay_idx];
            bus.replay_warp_ID_o     = warp_arr[replay_idx];
            bus.replay_scb_ID_o      = scb_arr[replay_idx];
            bus.replay_reg_addr_o    = rga_arr[replay_idx];
            bus.replay_thread_mask_o = mask_arr[replay_idx];
            bus.replay_is_write_o    = wr_arr[replay_idx];
        end
    end
endmodule

// File: tb/tb_mshr_miss_queue.sv
// Self-checking bench for mshr_miss_queue. A monitor logs every fill
// pulse and replay handshake with its cycle number; each scenario task
// pushes the events it expects into a cycle-ordered scoreboard and
// compares them against the log, plus inline checks of status outputs.
module tb_mshr_miss_queue;
    typedef struct packed {
        logic [31:0] cyc;
        logic        kind;   // 0 = fill, 1 = replay handshake
        logic [26:0] addr;
        logic [2:0]  warp;
        logic [1:0]  scb;
        logic [4:0]  rga;
        logic [7:0]  mask;
        logic        wr;
    } ev_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rd_ev = 0;
    int   t = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e_ev;
    ev_t  o_ev;

    mshr_miss_queue_if bus ();

    mshr_miss_queue #(.ENTRIES(4)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(int c, logic k, logic [26:0] a, logic [2:0] w,
                                  logic [1:0] s, logic [4:0] r, logic [7:0] m, logic wr);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        e.warp = w;
        e.scb  = s;
        e.rga  = r;
        e.mask = m;
        e.wr   = wr;
        return e;
    endfunction

    // Keep the scoreboard ordered by (cycle, kind) like the monitor log
    function automatic void exp_push(ev_t e);
        int k = 0;
        while (k < exp_q.size() && {exp_q[k].cyc, exp_q[k].kind} <= {e.cyc, e.kind}) k++;
        exp_q.insert(k, e);
    endfunction

    // Monitor: log fill pulses and replay handshakes away from the edge
    always @(negedge clk) begin
        if (resetb) begin
            if (bus.fill_valid_o) begin
                obs_q.push_back(mk_ev(cyc, 1'b0, bus.fill_addr_o, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
                $display("cyc %0d fill   addr %h", cyc, bus.fill_addr_o);
            end
            if (bus.replay_valid_o && bus.replay_ready_i) begin
                obs_q.push_back(mk_ev(cyc, 1'b1, bus.replay_addr_o, bus.replay_warp_ID_o,
                                      bus.replay_scb_ID_o, bus.replay_reg_addr_o,
                                      bus.replay_thread_mask_o, bus.replay_is_write_o));
                $display("cyc %0d replay addr %h warp %0d scb %0d reg %0d mask %h wr %0d",
                         cyc, bus.replay_addr_o, bus.replay_warp_ID_o, bus.replay_scb_ID_o,
                         bus.replay_reg_addr_o, bus.replay_thread_mask_o, bus.replay_is_write_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_miss(logic [26:0] a, logic [4:0] l, logic [2:0] w, logic [1:0] s,
                            logic [4:0] r, logic [7:0] m, logic wr);
        bus.miss_valid_i       = 1'b1;
        bus.miss_addr_i        = a;
        bus.miss_latency_i     = l;
        bus.miss_warp_ID_i     = w;
        bus.miss_scb_ID_i      = s;
        bus.miss_reg_addr_i    = r;
        bus.miss_thread_mask_i = m;
        bus.miss_is_write_i    = wr;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        bus.miss_valid_i = 1'b0;
        bus.miss_addr_i = '0;
        bus.miss_latency_i = '0;
        bus.miss_warp_ID_i = '0;
        bus.miss_scb_ID_i = '0;
        bus.miss_reg_addr_i = '0;
        bus.miss_thread_mask_i = '0;
        bus.miss_is_write_i = 1'b0;
        bus.replay_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
        rd_ev = obs_q.size();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL reset count: actual %0d required 0", bus.count_o); end
        n_checks++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset full: actual %b required 0", bus.full_o); end
        n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset overflow: actual %b required 0", bus.overflow_o); end
        n_checks++; if (bus.fill_valid_o !== 1'b0 || bus.fill_addr_o !== 27'd0) begin n_fail++; $display("FAIL reset fill: actual %b/%h required 0/0", bus.fill_valid_o, bus.fill_addr_o); end
        n_checks++; if (bus.replay_valid_o !== 1'b0 || bus.replay_addr_o !== 27'd0 || bus.replay_thread_mask_o !== 8'd0) begin n_fail++; $display("FAIL reset replay: actual %b/%h/%h required 0/0/0", bus.replay_valid_o, bus.replay_addr_o, bus.replay_thread_mask_o); end
    endtask

    task automatic test_single_miss();
        do_reset();
        bus.replay_ready_i = 1'b1;
        set_miss(27'h0000123, 5'd3, 3'd5, 2'd2, 5'd17, 8'hA5, 1'b0);
        step();
        t = cyc;
        bus.miss_valid_i = 1'b0;
        exp_push(mk_ev(t + 4, 1'b0, 27'h0000123, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 5, 1'b1, 27'h0000123, 3'd5, 2'd2, 5'd17, 8'hA5, 1'b0));
        n_checks++; if (bus.count_o !== 4'd1) begin n_fail++; $display("FAIL single count_after_alloc: actual %0d required 1", bus.count_o); end
        repeat (3) step();
        n_checks++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL single early_fill: actual %b required 0", bus.fill_valid_o); end
        step();
        n_checks++; if (bus.fill_valid_o !== 1'b1 || bus.fill_addr_o !== 27'h0000123) begin n_fail++; $display("FAIL single fill_t4: actual %b/%h required 1/0000123", bus.fill_valid_o, bus.fill_addr_o); end
        repeat (4) step();
        n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL single count_final: actual %0d required 0", bus.count_o); end
        while (exp_q.size() != 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (rd_ev >= obs_q.size()) begin n_fail++; $display("FAIL single event: actual none required %h", e_ev); end
            else begin
                o_ev = obs_q[rd_ev]; rd_ev++;
                if (o_ev !== e_ev) begin n_fail++; $display("FAIL single event: actual %h required %h", o_ev, e_ev); end
            end
        end
        n_checks++; if (rd_ev != obs_q.size()) begin n_fail++; $display("FAIL single extra_events: actual %0d required 0", obs_q.size() - rd_ev); rd_ev = obs_q.size(); end
    endtask

    task automatic test_dual_fill();
        do_reset();
        bus.replay_ready_i = 1'b1;
        set_miss(27'h4000001, 5'd2, 3'd1, 2'd1, 5'd3, 8'h0F, 1'b1);
        step();
        t = cyc;
        set_miss(27'h4000002, 5'd1, 3'd2, 2'd3, 5'd4, 8'hF0, 1'b0);
        step();
        bus.miss_valid_i = 1'b0;
        exp_push(mk_ev(t + 3, 1'b0, 27'h4000001, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 4, 1'b0, 27'h4000002, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 4, 1'b1, 27'h4000001, 3'd1, 2'd1, 5'd3, 8'h0F, 1'b1));
        exp_push(mk_ev(t + 5, 1'b1, 27'h4000002, 3'd2, 2'd3, 5'd4, 8'hF0, 1'b0));
        repeat (2) step();
        n_checks++; if (bus.fill_addr_o !== 27'h4000001) begin n_fail++; $display("FAIL dual first_fill: actual %h required 4000001", bus.fill_addr_o); end
        step();
        n_checks++; if (bus.fill_addr_o !== 27'h4000002) begin n_fail++; $display("FAIL dual second_fill: actual %h required 4000002", bus.fill_addr_o); end
        repeat (5) step();
        while (exp_q.size() != 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (rd_ev >= obs_q.size()) begin n_fail++; $display("FAIL dual event: actual none required %h", e_ev); end
            else begin
                o_ev = obs_q[rd_ev]; rd_ev++;
                if (o_ev !== e_ev) begin n_fail++; $display("FAIL dual event: actual %h required %h", o_ev, e_ev); end
            end
        end
        n_checks++; if (rd_ev != obs_q.size()) begin n_fail++; $display("FAIL dual extra_events: actual %0d required 0", obs_q.size() - rd_ev); rd_ev = obs_q.size(); end
    endtask

    task automatic test_replay_stall();
        do_reset();
        bus.replay_ready_i = 1'b0;
        set_miss(27'h0100000, 5'd0, 3'd1, 2'd1, 5'd1, 8'h01, 1'b0);
        step();
        t = cyc;
        set_miss(27'h0200000, 5'd3, 3'd2, 2'd2, 5'd2, 8'h02, 1'b1);
        step();
        set_miss(27'h0300000, 5'd0, 3'd3, 2'd3, 5'd3, 8'h04, 1'b0);
        step();
        bus.miss_valid_i = 1'b0;
        exp_push(mk_ev(t + 1, 1'b0, 27'h0100000, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 3, 1'b0, 27'h0300000, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 5, 1'b0, 27'h0200000, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(t + 9, 1'b1, 27'h0100000, 3'd1, 2'd1, 5'd1, 8'h01, 1'b0));
        exp_push(mk_ev(t + 10, 1'b1, 27'h0200000, 3'd2, 2'd2, 5'd2, 8'h02, 1'b1));
        exp_push(mk_ev(t + 11, 1'b1, 27'h0300000, 3'd3, 2'd3, 5'd3, 8'h04, 1'b0));
        while (cyc < t + 9) begin
            n_checks++;
            if (bus.replay_valid_o !== 1'b1 || bus.replay_addr_o !== 27'h0100000 || bus.replay_warp_ID_o !== 3'd1) begin
                n_fail++;
                $display("FAIL stall hold_entry0 cyc %0d: actual %b/%h/%0d required 1/0100000/1", cyc - t, bus.replay_valid_o, bus.replay_addr_o, bus.replay_warp_ID_o);
            end
            step();
        end
        bus.replay_ready_i = 1'b1;
        repeat (4) step();
        while (exp_q.size() != 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (rd_ev >= obs_q.size()) begin n_fail++; $display("FAIL stall event: actual none required %h", e_ev); end
            else begin
                o_ev = obs_q[rd_ev]; rd_ev++;
                if (o_ev !== e_ev) begin n_fail++; $display("FAIL stall event: actual %h required %h", o_ev, e_ev); end
            end
        end
        n_checks++; if (rd_ev != obs_q.size()) begin n_fail++; $display("FAIL stall extra_events: actual %0d required 0", obs_q.size() - rd_ev); rd_ev = obs_q.size(); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.replay_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_miss(27'h0600000 + 27'(i), 5'd10, 3'(i), 2'(i), 5'(i + 20), 8'(8'h80 >> i), 1'(i));
            step();
            if (i == 0) t = cyc;
            if (i < 4) begin
                exp_push(mk_ev(t + i + 11, 1'b0, 27'h0600000 + 27'(i), 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
                exp_push(mk_ev(t + i + 12, 1'b1, 27'h0600000 + 27'(i), 3'(i), 2'(i), 5'(i + 20), 8'(8'h80 >> i), 1'(i)));
            end
            if (i == 3) begin
                n_checks++; if (bus.full_o !== 1'b1 || bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL overflow full_after_4th: actual full %b ovf %b required 1 0", bus.full_o, bus.overflow_o); end
            end
        end
        bus.miss_valid_i = 1'b0;
        n_checks++; if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow sticky_set: actual %b required 1", bus.overflow_o); end
        n_checks++; if (bus.count_o !== 4'd4 || bus.full_o !== 1'b1) begin n_fail++; $display("FAIL overflow count4: actual %0d/%b required 4/1", bus.count_o, bus.full_o); end
        repeat (16) step();
        n_checks++; if (bus.overflow_o !== 1'b1 || bus.count_o !== 4'd0) begin n_fail++; $display("FAIL overflow after_drain: actual ovf %b count %0d required 1 0", bus.overflow_o, bus.count_o); end
        while (exp_q.size() != 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (rd_ev >= obs_q.size()) begin n_fail++; $display("FAIL overflow event: actual none required %h", e_ev); end
            else begin
                o_ev = obs_q[rd_ev]; rd_ev++;
                if (o_ev !== e_ev) begin n_fail++; $display("FAIL overflow event: actual %h required %h", o_ev, e_ev); end
            end
        end
        n_checks++; if (rd_ev != obs_q.size()) begin n_fail++; $display("FAIL overflow extra_events: actual %0d required 0", obs_q.size() - rd_ev); rd_ev = obs_q.size(); end
    endtask

    task automatic test_full_replay_same_edge();
        int c;
        do_reset();
        bus.replay_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_miss(27'h0500000 + 27'(i), 5'd0, 3'(i), 2'(i), 5'(i + 8), 8'(8'h01 << i), 1'(i));
            step();
            if (i == 0) t = cyc;
            exp_push(mk_ev(t + i + 1, 1'b0, 27'h0500000 + 27'(i), 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        end
        bus.miss_valid_i = 1'b0;
        repeat (3) step();
        c = cyc;
        exp_push(mk_ev(c, 1'b1, 27'h0500000, 3'd0, 2'd0, 5'd8, 8'h01, 1'b0));
        exp_push(mk_ev(c + 3, 1'b0, 27'h7FFFFFF, 3'd0, 2'd0, 5'd0, 8'd0, 1'b0));
        exp_push(mk_ev(c + 6, 1'b1, 27'h0500001, 3'd1, 2'd1, 5'd9, 8'h02, 1'b1));
        exp_push(mk_ev(c + 7, 1'b1, 27'h7FFFFFF, 3'd7, 2'd3, 5'd31, 8'hFF, 1'b1));
        exp_push(mk_ev(c + 8, 1'b1, 27'h0500002, 3'd2, 2'd2, 5'd10, 8'h04, 1'b0));
        exp_push(mk_ev(c + 9, 1'b1, 27'h0500003, 3'd3, 2'd3, 5'd11, 8'h08, 1'b1));
        n_checks++; if (bus.full_o !== 1'b1 || bus.count_o !== 4'd4) begin n_fail++; $display("FAIL fullrep full_before: actual %b/%0d required 1/4", bus.full_o, bus.count_o); end
        bus.replay_ready_i = 1'b1;
        set_miss(27'h7FFFFFF, 5'd0, 3'd7, 2'd3, 5'd31, 8'hFF, 1'b1);
        step();
        bus.replay_ready_i = 1'b0;
        n_checks++; if (bus.count_o !== 4'd3 || bus.full_o !== 1'b0 || bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL fullrep dropped: actual count %0d full %b ovf %b required 3 0 1", bus.count_o, bus.full_o, bus.overflow_o); end
        step();
        bus.miss_valid_i = 1'b0;
        n_checks++; if (bus.count_o !== 4'd4 || bus.full_o !== 1'b1) begin n_fail++; $display("FAIL fullrep retry_accepted: actual %0d/%b required 4/1", bus.count_o, bus.full_o); end
        repeat (3) step();
        n_checks++; if (bus.replay_addr_o !== 27'h0500001) begin n_fail++; $display("FAIL fullrep hold_lock: actual %h required 0500001", bus.replay_addr_o); end
        step();
        bus.replay_ready_i = 1'b1;
        repeat (5) step();
        while (exp_q.size() != 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (rd_ev >= obs_q.size()) begin n_fail++; $display("FAIL fullrep event: actual none required %h", e_ev); end
            else begin
                o_ev = obs_q[rd_ev]; rd_ev++;
                if (o_ev !== e_ev) begin n_fail++; $display("FAIL fullrep event: actual %h required %h", o_ev, e_ev); end
            end
        end
        n_checks++; if (rd_ev != obs_q.size()) begin n_fail++; $display("FAIL fullrep extra_events: actual %0d required 0", obs_q.size() - rd_ev); rd_ev = obs_q.size(); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.replay_ready_i = 1'b0;
        set_miss(27'h0A00000, 5'd0, 3'd1, 2'd0, 5'd1, 8'h11, 1'b0);
        step();
        t = cyc;
        set_miss(27'h0B00000, 5'd1, 3'd2, 2'd1, 5'd2, 8'h22, 1'b0);
        step();
        set_miss(27'h0C00000, 5'd8, 3'd3, 2'd2, 5'd3, 8'h33, 1'b1);
        step();
        bus.miss_valid_i = 1'b0;
        step();
        n_checks++; if (bus.count_o !== 4'd3 || bus.fill_valid_o !== 1'b1 || bus.replay_valid_o !== 1'b1) begin n_fail++; $display("FAIL midrst busy_before: actual count %0d fill %b replay %b required 3 1 1", bus.count_o, bus.fill_valid_o, bus.replay_valid_o); end
        resetb = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd0 || bus.full_o !== 1'b0 || bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL midrst status: actual count %0d full %b ovf %b required 0 0 0", bus.count_o, bus.full_o, bus.overflow_o); end
        n_checks++; if (bus.fill_valid_o !== 1'b0 || bus.fill_addr_o !== 27'd0 || bus.replay_valid_o !== 1'b0 || bus.replay_addr_o !== 27'd0) begin n_fail++; $display("FAIL midrst ports: actual %b/%h/%b/%h required 0/0/0/0", bus.fill_valid_o, bus.fill_addr_o, bus.replay_valid_o, bus.replay_addr_o); end
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
        rd_ev = obs_q.size();
        bus.replay_ready_i = 1'b1;
        repeat (15) step();
        n_checks++; if (obs_q.size() != rd_ev || bus.count_o !== 4'd0) begin n_fail++; $display("FAIL midrst no_issue_after: actual events %0d count %0d required 0 0", obs_q.size() - rd_ev, bus.count_o); end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_miss();
        test_dual_fill();
        test_replay_stall();
        test_overflow();
        test_full_replay_same_edge();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
